lif_neuron_core: RTL and testbench

Leaky integrate-and-fire (LIF) neuron stage that sits directly downstream of `fifo_wrapper`. It drains signed synaptic-weight words from the first-word-fall-through (FWFT) FIFO and integrates them into a saturating membrane potential. On each timestep tick it applies a shift-based leak, compares the potential against a threshold, emits a one-cycle spike, then enters a tick-counted refractory period.

---
 rtl/neuro_pkg.sv | 37 +++
 rtl/lif_neuron_core.sv | 135 +++++++++++++
 tb/tb_lif_neuron_core.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/neuro_pkg.sv
// Shared types, defaults and helpers for the neuromorphic datapath blocks.
package neuro_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    LEAK    = 2'd1,
    FIRE    = 2'd2,
    REFRACT = 2'd3
  } lif_state_e;

  localparam int LIF_THRESHOLD     = 1000;
  localparam int LIF_LEAK_SHIFT    = 4;
  localparam int LIF_REFRACT_TICKS = 2;

  // Saturating signed add clamped to the signed range of `width` bits.
  // Operands arrive sign-extended to 64 bits, so the raw sum cannot overflow
  // for any width up to 63; callers truncate the result back to `width`.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] pot,
    input logic signed [63:0] w,
    input int unsigned        width
  );
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = pot + w;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron draining signed weights from an FWFT FIFO.
module lif_neuron_core
  import neuro_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_W      = 16,
  parameter int POT_W         = 24,
  parameter int THRESHOLD     = LIF_THRESHOLD,
  parameter int LEAK_SHIFT    = LIF_LEAK_SHIFT,
  parameter int REFRACT_TICKS = LIF_REFRACT_TICKS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tick_i,
  input  logic                    fifo_empty_i,
  input  logic                    fifo_rst_busy_i,
  input  logic [DATA_WIDTH-1:0]   fifo_dout_i,
  output logic                    fifo_rd_en_o,
  output logic                    spike_o,
  output logic signed [POT_W-1:0] potential_o,
  output logic                    refract_o,
  output logic [15:0]             spike_cnt_o
);

  localparam int RC_W = (REFRACT_TICKS > 1) ? $clog2(REFRACT_TICKS + 1) : 1;
  localparam logic signed [POT_W-1:0] THR = POT_W'(THRESHOLD);

  lif_state_e                 state_q, state_d;
  logic signed [POT_W-1:0]    pot_q, pot_d;
  logic signed [POT_W-1:0]    leaked;
  logic signed [WEIGHT_W-1:0] weight;
  logic                       spike_q, spike_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [RC_W-1:0]            rcnt_q, rcnt_d;
  logic                       pend_q, pend_d;
  logic                       tick_eff;
  logic                       unused_hi;

  assign weight    = fifo_dout_i[WEIGHT_W-1:0];
  assign unused_hi = ^fifo_dout_i[DATA_WIDTH-1:WEIGHT_W];
  assign leaked    = pot_q - (pot_q >>> LEAK_SHIFT);
  // A pending tick and a live tick in the same cycle count as one tick.
  assign tick_eff  = tick_i | pend_q;

  // Pop whenever draining states see data and the FIFO is out of reset.
  always_comb begin
    fifo_rd_en_o = rst_i && (state_q == ACCUM || state_q == REFRACT)
                   && !fifo_empty_i && !fifo_rst_busy_i;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pot_d   = pot_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    pend_d  = pend_q;
    case (state_q)
      ACCUM: begin
        if (fifo_rd_en_o) begin
          pot_d = POT_W'(sat_add(64'(pot_q), 64'(weight), POT_W));
        end
        if (tick_eff) begin
          state_d = LEAK;
        end
        pend_d = 1'b0;
      end
      LEAK: begin
        pot_d = leaked;
        if (leaked >= THR) begin
          state_d = FIRE;
          spike_d = 1'b1;
        end else begin
          state_d = ACCUM;
        end
        if (tick_i) begin
          pend_d = 1'b1;
        end
      end
      FIRE: begin
        pot_d   = '0;
        cnt_d   = cnt_q + 16'd1;
        rcnt_d  = RC_W'(REFRACT_TICKS);
        state_d = (REFRACT_TICKS > 0) ? REFRACT : ACCUM;
        if (tick_i) begin
          pend_d = 1'b1;
        end
      end
      REFRACT: begin
        // Popped words are discarded here; potential stays at zero.
        pend_d = 1'b0;
        if (tick_eff) begin
          rcnt_d = rcnt_q - RC_W'(1);
          if (rcnt_q == RC_W'(1)) begin
            state_d = ACCUM;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pot_q   <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      pot_q   <= pot_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
    end
  end

  assign spike_o     = spike_q;
  assign potential_o = pot_q;
  assign refract_o   = (state_q == REFRACT);
  assign spike_cnt_o = cnt_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core with a behavioural FWFT FIFO in front.
module tb_lif_neuron_core;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        tick_i = 1'b0;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_rst_busy_i = 1'b0;
  logic [31:0] fifo_dout_i = '0;
  logic        fifo_rd_en_o;
  logic        spike_o;
  logic [23:0] potential_o;
  logic        refract_o;
  logic [15:0] spike_cnt_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] q[$];
  logic        pop_now = 1'b0;

  lif_neuron_core #(
    .DATA_WIDTH   (32),
    .WEIGHT_W     (16),
    .POT_W        (24),
    .THRESHOLD    (1000),
    .LEAK_SHIFT   (4),
    .REFRACT_TICKS(2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .tick_i         (tick_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rst_busy_i(fifo_rst_busy_i),
    .fifo_dout_i    (fifo_dout_i),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .spike_o        (spike_o),
    .potential_o    (potential_o),
    .refract_o      (refract_o),
    .spike_cnt_o    (spike_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // FWFT FIFO model: flags refreshed shortly after each edge, pop decided
  // from the read strobe sampled while inputs are stable.
  always begin
    @(negedge clk_i);
    #1;
    fifo_empty_i = (q.size() == 0);
    fifo_dout_i  = (q.size() == 0) ? 32'h0 : q[0];
    #1;
    pop_now = fifo_rd_en_o;
    @(posedge clk_i);
    #1;
    if (pop_now && q.size() > 0) void'(q.pop_front());
    fifo_empty_i = (q.size() == 0);
    fifo_dout_i  = (q.size() == 0) ? 32'h0 : q[0];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
  endtask

  task automatic do_tick();
    tick_i = 1'b1;
    @(negedge clk_i);
    tick_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!fifo_empty_i && n < budget);
    chk(tag, 32'(fifo_empty_i), 32'd1);
  endtask

  initial begin
    // Reset state, including gating of the pop strobe by reset.
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    push(32'd5);
    @(negedge clk_i);
    #2;
    chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("rst_pot", 32'(potential_o), 32'd0);
    chk("rst_spike", 32'(spike_o), 32'd0);
    chk("rst_refract", 32'(refract_o), 32'd0);
    chk("rst_cnt", 32'(spike_cnt_o), 32'd0);
    q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Fire: 600 + 500 = 1100, leak 1100 - 68 = 1032 >= 1000.
    push(32'd600);
    push(32'd500);
    wait_empty("fire_empty", 20);
    chk("fire_pot_acc", 32'(potential_o), 32'd1100);
    do_tick();
    chk("fire_leak_pot", 32'(potential_o), 32'd1100);
    chk("fire_leak_spike", 32'(spike_o), 32'd0);
    @(negedge clk_i);
    chk("fire_spike", 32'(spike_o), 32'd1);
    chk("fire_pot_leaked", 32'(potential_o), 32'd1032);
    @(negedge clk_i);
    chk("fire_spike_off", 32'(spike_o), 32'd0);
    chk("fire_pot_zero", 32'(potential_o), 32'd0);
    chk("fire_cnt", 32'(spike_cnt_o), 32'd1);
    chk("fire_refract", 32'(refract_o), 32'd1);

    // Refractory: words are drained but discarded.
    push(32'd2000);
    #2;
    chk("refr_rd_en", 32'(fifo_rd_en_o), 32'd1);
    @(negedge clk_i);
    chk("refr_pot_hold", 32'(potential_o), 32'd0);
    chk("refr_drained", 32'(fifo_empty_i), 32'd1);
    do_tick();
    chk("refr_tick1", 32'(refract_o), 32'd1);
    do_tick();
    chk("refr_tick2", 32'(refract_o), 32'd0);
    push(32'd1200);
    wait_empty("refr_empty", 20);
    chk("refr_pot_acc", 32'(potential_o), 32'd1200);
    do_tick();
    @(negedge clk_i);
    chk("refr_spike2", 32'(spike_o), 32'd1);
    chk("refr_pot_leaked", 32'(potential_o), 32'd1125);
    @(negedge clk_i);
    chk("refr_cnt2", 32'(spike_cnt_o), 32'd2);

    // No fire: 900 - 56 = 844, back in ACCUM.
    do_reset();
    push(32'd900);
    wait_empty("nofire_empty", 20);
    chk("nofire_pot_acc", 32'(potential_o), 32'd900);
    do_tick();
    @(negedge clk_i);
    chk("nofire_pot", 32'(potential_o), 32'd844);
    chk("nofire_spike", 32'(spike_o), 32'd0);
    chk("nofire_refract", 32'(refract_o), 32'd0);
    push(32'd10);
    wait_empty("nofire_empty2", 20);
    chk("nofire_accum", 32'(potential_o), 32'd854);

    // Positive saturation; upper FIFO bits carry junk that must be ignored.
    do_reset();
    for (int i = 0; i < 300; i++) push(32'hABCD7FFF);
    wait_empty("satp_empty", 400);
    chk("satp_pot", 32'(potential_o), 32'h007FFFFF);
    push(32'd1);
    wait_empty("satp_empty2", 20);
    chk("satp_hold", 32'(potential_o), 32'h007FFFFF);

    // Negative saturation.
    do_reset();
    for (int i = 0; i < 300; i++) push(32'h12348000);
    wait_empty("satn_empty", 400);
    chk("satn_pot", 32'(potential_o), 32'h00800000);

    // Pending tick: second tick during LEAK shortens refractory to one tick.
    do_reset();
    push(32'd1100);
    wait_empty("pend_empty", 20);
    tick_i = 1'b1;
    @(negedge clk_i);
    chk("pend_leak_pot", 32'(potential_o), 32'd1100);
    @(negedge clk_i);
    tick_i = 1'b0;
    chk("pend_spike", 32'(spike_o), 32'd1);
    chk("pend_pot_leaked", 32'(potential_o), 32'd1032);
    @(negedge clk_i);
    chk("pend_refract", 32'(refract_o), 32'd1);
    chk("pend_cnt", 32'(spike_cnt_o), 32'd1);
    @(negedge clk_i);
    chk("pend_still_refr", 32'(refract_o), 32'd1);
    do_tick();
    chk("pend_exit", 32'(refract_o), 32'd0);

    // FIFO reset-busy blocks pops and holds the potential.
    do_reset();
    fifo_rst_busy_i = 1'b1;
    push(32'd500);
    #2;
    chk("busy_rd_en", 32'(fifo_rd_en_o), 32'd0);
    repeat (3) @(negedge clk_i);
    chk("busy_pot", 32'(potential_o), 32'd0);
    chk("busy_not_popped", 32'(fifo_empty_i), 32'd0);
    fifo_rst_busy_i = 1'b0;
    wait_empty("busy_empty", 20);
    chk("busy_release_pot", 32'(potential_o), 32'd500);

    // Asynchronous reset in the middle of FIRE.
    push(32'd600);
    wait_empty("arst_empty", 20);
    do_tick();
    @(negedge clk_i);
    chk("arst_in_fire", 32'(spike_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("arst_spike", 32'(spike_o), 32'd0);
    chk("arst_pot", 32'(potential_o), 32'd0);
    chk("arst_cnt", 32'(spike_cnt_o), 32'd0);
    chk("arst_refract", 32'(refract_o), 32'd0);
    chk("arst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    push(32'd100);
    wait_empty("arst_empty2", 20);
    chk("arst_accum_pot", 32'(potential_o), 32'd100);
    chk("arst_accum_refr", 32'(refract_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
